fetch_ctrl: RTL and testbench

Program-counter sequencer for the instruction-fetch stage. It generates the PC presented to fetch every cycle and drives fetch's stall input. It applies hazard stalls, taken-branch/jump redirects, debug halt/resume, and address-fault detection, and it issues a one-cycle flush so the wrong-path instruction already latched by fetch is squashed.

---
 rtl/fetch_ctrl_if.sv | 35 +++
 rtl/fetch_ctrl.sv | 158 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// ============================================================================
// fetch_ctrl_if : hazard/redirect/debug bus between the core and fetch_ctrl
// Revision      : 1.0
// ============================================================================
`default_nettype none

interface fetch_ctrl_if;
  logic        stall_i;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc_next;
  logic        fetch_stall;
  logic        flush_o;
  logic [1:0]  state_o;
  logic        fault_o;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
  logic [31:0] redirect_count;

  modport master (
    output stall_i, redirect_valid, redirect_pc, halt_req, resume,
    input  pc_next, fetch_stall, flush_o, state_o, fault_o,
    input  fetch_count, stall_count, redirect_count
  );

  modport slave (
    input  stall_i, redirect_valid, redirect_pc, halt_req, resume,
    output pc_next, fetch_stall, flush_o, state_o, fault_o,
    output fetch_count, stall_count, redirect_count
  );
endinterface

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// fetch_ctrl : PC sequencer with stall, redirect, debug halt and address fault
//              Optional perf counters under `FETCH_CTRL_PERF_EN.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 256
) (
  input  wire logic  clk,
  input  wire logic  reset,
  fetch_ctrl_if.slave bus
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [32:0] C_PC_LIMIT = 33'(IMEM_DEPTH) * 33'd4;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        flush_q, flush_d;
  logic        fault_q, fault_d;

  logic        redirect_bad;
  logic        seq_wrap;
  logic        redirect_ok;

  assign redirect_bad = (bus.redirect_pc[1:0] != 2'b00) ||
                        ({1'b0, bus.redirect_pc} >= C_PC_LIMIT);
  // Computed in 33 bits so a limit of 2^32 still traps instead of wrapping.
  assign seq_wrap     = ({1'b0, pc_q} + 33'd4) >= C_PC_LIMIT;
  assign redirect_ok  = ((state_q == S_RUN) || (state_q == S_HALT)) &&
                        bus.redirect_valid && !redirect_bad;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = 1'b0;
    fault_d = fault_q;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (bus.redirect_valid) begin
          if (redirect_bad) begin
            state_d = S_FAULT;
          end else begin
            pc_d    = bus.redirect_pc;
            flush_d = 1'b1;
          end
        end else if (bus.halt_req) begin
          state_d = S_HALT;
        end else if (bus.stall_i) begin
          pc_d = pc_q;
        end else if (seq_wrap) begin
          state_d = S_FAULT;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      S_HALT: begin
        if (bus.redirect_valid) begin
          if (redirect_bad) begin
            state_d = S_FAULT;
          end else begin
            pc_d    = bus.redirect_pc;
            flush_d = 1'b1;
            if (bus.resume && !bus.halt_req) state_d = S_RUN;
          end
        end else if (bus.resume && !bus.halt_req) begin
          state_d = S_RUN;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_BOOT;
    endcase
    // FAULT keeps flush asserted every cycle it is occupied.
    if (state_d == S_FAULT) begin
      fault_d = 1'b1;
      flush_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    bus.fetch_stall = 1'b1;
    if (state_q == S_RUN) bus.fetch_stall = bus.stall_i & ~bus.redirect_valid;
  end

  assign bus.pc_next = pc_q;
  assign bus.flush_o = flush_q;
  assign bus.state_o = state_q;
  assign bus.fault_o = fault_q;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] redirect_count_q, redirect_count_d;
  logic        run_quiet;

  assign run_quiet = (state_q == S_RUN) && !bus.redirect_valid && !bus.halt_req;

  always_comb begin
    fetch_count_d    = fetch_count_q;
    stall_count_d    = stall_count_q;
    redirect_count_d = redirect_count_q;
    if (run_quiet && !bus.stall_i && !seq_wrap && (fetch_count_q != 32'hFFFF_FFFF))
      fetch_count_d = fetch_count_q + 32'd1;
    if (run_quiet && bus.stall_i && (stall_count_q != 32'hFFFF_FFFF))
      stall_count_d = stall_count_q + 32'd1;
    if (redirect_ok && (redirect_count_q != 32'hFFFF_FFFF))
      redirect_count_d = redirect_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q    <= 32'd0;
      stall_count_q    <= 32'd0;
      redirect_count_q <= 32'd0;
    end else begin
      fetch_count_q    <= fetch_count_d;
      stall_count_q    <= stall_count_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign bus.fetch_count    = fetch_count_q;
  assign bus.stall_count    = stall_count_q;
  assign bus.redirect_count = redirect_count_q;
`else
  logic unused_redirect_ok;
  assign unused_redirect_ok = redirect_ok;

  assign bus.fetch_count    = 32'd0;
  assign bus.stall_count    = 32'd0;
  assign bus.redirect_count = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// tb_fetch_ctrl : directed self-checking bench for fetch_ctrl
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_DEPTH (256)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt(input logic [31:0] v);
`ifdef FETCH_CTRL_PERF_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  // Full snapshot of registered outputs.
  task automatic snap(input string tag, input logic [31:0] pc, input logic [1:0] st,
                      input logic fl, input logic ft,
                      input logic [31:0] fc, input logic [31:0] sc, input logic [31:0] rc);
    chk({tag, ".pc"},    bus.pc_next,        pc);
    chk({tag, ".state"}, 32'(bus.state_o),   32'(st));
    chk({tag, ".flush"}, 32'(bus.flush_o),   32'(fl));
    chk({tag, ".fault"}, 32'(bus.fault_o),   32'(ft));
    chk({tag, ".fcnt"},  bus.fetch_count,    cnt(fc));
    chk({tag, ".scnt"},  bus.stall_count,    cnt(sc));
    chk({tag, ".rcnt"},  bus.redirect_count, cnt(rc));
  endtask

  task automatic stall_is(input string tag, input logic exp);
    #1;
    chk(tag, 32'(bus.fetch_stall), 32'(exp));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.stall_i = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.halt_req = 1'b0;
    bus.resume = 1'b0;

    tick; tick;
    snap("reset", 32'h0, 2'd0, 1'b0, 1'b0, 0, 0, 0);
    stall_is("reset.fstall", 1'b1);

    // Boot then sequential fetch
    rst = 1'b0;
    tick; snap("boot", 32'h0, 2'd1, 1'b0, 1'b0, 0, 0, 0);
    stall_is("run.fstall", 1'b0);
    tick; snap("seq4", 32'h4, 2'd1, 1'b0, 1'b0, 1, 0, 0);
    tick; snap("seq8", 32'h8, 2'd1, 1'b0, 1'b0, 2, 0, 0);
    tick; snap("seqC", 32'hC, 2'd1, 1'b0, 1'b0, 3, 0, 0);

    // Stall, then redirect overriding stall
    bus.stall_i = 1'b1;
    stall_is("stall.fstall", 1'b1);
    tick; snap("stall1", 32'hC, 2'd1, 1'b0, 1'b0, 3, 1, 0);
    tick; snap("stall2", 32'hC, 2'd1, 1'b0, 1'b0, 3, 2, 0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    stall_is("redir.fstall", 1'b0);
    tick; snap("redir40", 32'h40, 2'd1, 1'b1, 1'b0, 3, 2, 1);
    bus.stall_i = 1'b0;
    bus.redirect_valid = 1'b0;
    tick; snap("after40", 32'h44, 2'd1, 1'b0, 1'b0, 4, 2, 1);

    // Halt / resume
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h10;
    tick; snap("redir10", 32'h10, 2'd1, 1'b1, 1'b0, 4, 2, 2);
    bus.redirect_valid = 1'b0;
    bus.halt_req = 1'b1;
    tick; snap("halt", 32'h10, 2'd2, 1'b0, 1'b0, 4, 2, 2);
    bus.halt_req = 1'b0;
    stall_is("halt.fstall", 1'b1);
    tick; snap("halt2", 32'h10, 2'd2, 1'b0, 1'b0, 4, 2, 2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h20;
    tick; snap("haltredir", 32'h20, 2'd2, 1'b1, 1'b0, 4, 2, 3);
    bus.redirect_valid = 1'b0;
    bus.resume = 1'b1;
    tick; snap("resume", 32'h20, 2'd1, 1'b0, 1'b0, 4, 2, 3);
    bus.resume = 1'b0;
    stall_is("resume.fstall", 1'b0);
    tick; snap("res24", 32'h24, 2'd1, 1'b0, 1'b0, 5, 2, 3);
    tick; snap("res28", 32'h28, 2'd1, 1'b0, 1'b0, 6, 2, 3);

    // halt_req wins over simultaneous resume
    bus.halt_req = 1'b1;
    tick; snap("halt28", 32'h28, 2'd2, 1'b0, 1'b0, 6, 2, 3);
    bus.resume = 1'b1;
    tick; snap("haltres", 32'h28, 2'd2, 1'b0, 1'b0, 6, 2, 3);
    bus.halt_req = 1'b0;
    tick; snap("res2", 32'h28, 2'd1, 1'b0, 1'b0, 6, 2, 3);
    bus.resume = 1'b0;
    tick; snap("seq2C", 32'h2C, 2'd1, 1'b0, 1'b0, 7, 2, 3);

    // Misaligned redirect
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h42;
    tick; snap("misal", 32'h2C, 2'd3, 1'b1, 1'b1, 7, 2, 3);
    bus.redirect_valid = 1'b0;
    stall_is("misal.fstall", 1'b1);
    tick; snap("misal2", 32'h2C, 2'd3, 1'b1, 1'b1, 7, 2, 3);
    bus.resume = 1'b1;
    tick; snap("misal3", 32'h2C, 2'd3, 1'b1, 1'b1, 7, 2, 3);
    bus.resume = 1'b0;

    // Sequential range fault at the top of memory
    rst = 1'b1;
    tick; snap("rst2", 32'h0, 2'd0, 1'b0, 1'b0, 0, 0, 0);
    rst = 1'b0;
    tick;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h3FC;
    tick; snap("top", 32'h3FC, 2'd1, 1'b1, 1'b0, 0, 0, 1);
    bus.redirect_valid = 1'b0;
    stall_is("top.fstall", 1'b0);
    tick; snap("wrap", 32'h3FC, 2'd3, 1'b1, 1'b1, 0, 0, 1);

    // Out-of-range redirect
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h400;
    tick; snap("range", 32'h0, 2'd3, 1'b1, 1'b1, 0, 0, 0);
    bus.redirect_valid = 1'b0;

    // Reset while a redirect flush is pending
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h80;
    tick; snap("pre", 32'h80, 2'd1, 1'b1, 1'b0, 0, 0, 1);
    bus.redirect_valid = 1'b0;
    rst = 1'b1;
    tick; snap("midrst", 32'h0, 2'd0, 1'b0, 1'b0, 0, 0, 0);
    stall_is("midrst.fstall", 1'b1);
    rst = 1'b0;
    tick; snap("reboot", 32'h0, 2'd1, 1'b0, 1'b0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
